// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter for four requesters with a bounded hold time per grant.
// All outputs are registered; the winner is reported one-hot and as a 2-bit index.
module rr_req_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter bit          GAP_EN   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

    state_t     state;
    logic [1:0] ptr;
    logic [3:0] hold_cnt;

    logic [3:0] others;
    logic       cur_req;
    logic       limit_hit;
    logic       end_grant;
    logic [1:0] nxt_ptr;
    logic [1:0] pick_idle;
    logic [1:0] pick_next;

    // First requester at or after p, wrapping 3->0.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] res;
        logic [1:0] c;
        logic       found;
        res   = p;
        found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            c = p + k[1:0];
            if (!found && r[c]) begin
                res   = c;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        others    = req & ~gnt;
        cur_req   = req[gnt_idx];
        limit_hit = (hold_cnt == HOLD_LIM) && (|others);
        end_grant = !cur_req || limit_hit;
        nxt_ptr   = gnt_idx + 2'd1;
        pick_idle = pick(req, ptr);
        pick_next = pick(others, nxt_ptr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (|req) begin
                        state     <= GRANT;
                        gnt       <= 4'b0001 << pick_idle;
                        gnt_idx   <= pick_idle;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (end_grant) begin
                        ptr     <= nxt_ptr;
                        preempt <= cur_req && limit_hit;
                        if (!GAP_EN && (|others)) begin
                            // Back-to-back handoff: outgoing requester is masked out.
                            gnt      <= 4'b0001 << pick_next;
                            gnt_idx  <= pick_next;
                            hold_cnt <= '0;
                        end else begin
                            state     <= GAP_EN ? GAP : IDLE;
                            gnt       <= '0;
                            gnt_idx   <= '0;
                            gnt_valid <= 1'b0;
                            hold_cnt  <= '0;
                        end
                    end else if (hold_cnt != HOLD_LIM) begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_idx   <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
